// File: rtl/sad_disp_search.sv
// sad_disp_search: sequential SAD disparity search.
// A job (left WINxWIN window + right search strip) is captured on accept,
// then one disparity is evaluated per cycle through a single SAD datapath
// (one row-SAD unit per window row, summed). The running minimum is tracked
// with strict less-than so ties keep the lower disparity. The result is
// offered on a valid/ready handshake.
// Optional feature macro: SAD_DISP_THRESH_EN
//   defined     -> disp_ok = (min_sad <= SAD_THRESH), registered with result
//   not defined -> disp_ok follows out_valid, no threshold comparator

// Row SAD: sum over one window row of |L(c) - R(c + MAX_DISP-1 - d)|
module sad_row #(
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int MAX_DISP  = 64,
    parameter int STRIP_W   = WIN + MAX_DISP - 1,
    parameter int SAD_SIZE  = 16,
    parameter int DISP_W    = 6
) (
    input  logic [DATA_SIZE*WIN-1:0]     left,
    input  logic [DATA_SIZE*STRIP_W-1:0] right,
    input  logic [DISP_W-1:0]            d,
    output logic [SAD_SIZE-1:0]          sum
);
    logic [DATA_SIZE-1:0] lp, rp, ad;
    int                   base;

    // Accumulate absolute differences across the row for disparity d
    always_comb begin
        sum  = '0;
        lp   = '0;
        rp   = '0;
        ad   = '0;
        base = 0;
        for (int c = 0; c < WIN; c++) begin
            base = c + MAX_DISP - 1 - int'(d);
            lp   = left[c*DATA_SIZE +: DATA_SIZE];
            rp   = right[base*DATA_SIZE +: DATA_SIZE];
            ad   = (lp >= rp) ? (lp - rp) : (rp - lp);
            sum  = sum + SAD_SIZE'(ad);
        end
    end
endmodule

module sad_disp_search #(
    parameter int WIN        = 15,
    parameter int DATA_SIZE  = 8,
    parameter int MAX_DISP   = 64,
    parameter int STRIP_W    = WIN + MAX_DISP - 1,
    parameter int SAD_SIZE   = $clog2(WIN*WIN*((1<<DATA_SIZE)-1)+1),
    parameter int DISP_W     = $clog2(MAX_DISP),
    parameter int SAD_THRESH = 1000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_SIZE*WIN*WIN-1:0]     win_l,
    input  logic [DATA_SIZE*WIN*STRIP_W-1:0] strip_r,
    input  logic [DISP_W-1:0]                disp_lim,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DISP_W-1:0]                best_disp,
    output logic [SAD_SIZE-1:0]              min_sad,
    output logic                             disp_ok
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int ROW_L = DATA_SIZE * WIN;
    localparam int ROW_R = DATA_SIZE * STRIP_W;

    logic [1:0]                       state;
    logic [DATA_SIZE*WIN*WIN-1:0]     win_q;
    logic [DATA_SIZE*WIN*STRIP_W-1:0] strip_q;
    logic [DISP_W-1:0]                lim, lim_in, d;
    logic [SAD_SIZE-1:0]              run_min, nxt_min, min_q;
    logic [DISP_W-1:0]                run_disp, nxt_disp, best_q;
    logic [WIN-1:0][SAD_SIZE-1:0]     row_sad;
    logic [SAD_SIZE-1:0]              sad;
    logic                             better;
    logic                             accept;

    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept = in_valid && in_ready;
    assign best_disp = best_q;
    assign min_sad = min_q;

    // Clamp the requested range to the largest supported disparity
    always_comb begin
        lim_in = disp_lim;
        if ({{(32-DISP_W){1'b0}}, disp_lim} > 32'(MAX_DISP - 1))
            lim_in = DISP_W'(MAX_DISP - 1);
    end

    // One row-SAD unit per window row, all looking at the same disparity
    for (genvar r = 0; r < WIN; r++) begin : g_row
        sad_row #(
            .WIN       (WIN),
            .DATA_SIZE (DATA_SIZE),
            .MAX_DISP  (MAX_DISP),
            .STRIP_W   (STRIP_W),
            .SAD_SIZE  (SAD_SIZE),
            .DISP_W    (DISP_W)
        ) u_row (
            .left  (win_q[r*ROW_L +: ROW_L]),
            .right (strip_q[r*ROW_R +: ROW_R]),
            .d     (d),
            .sum   (row_sad[r])
        );
    end

    // Sum row SADs at full width; SAD_SIZE holds the worst case exactly
    always_comb begin
        sad = '0;
        for (int r = 0; r < WIN; r++)
            sad = sad + row_sad[r];
    end

    // Strict compare: equal SADs keep the earlier (lower) disparity
    always_comb begin
        better   = (sad < run_min);
        nxt_min  = better ? sad : run_min;
        nxt_disp = better ? d : run_disp;
    end

    // Job data is captured on accept only; it is read only while searching
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q   <= win_l;
            strip_q <= strip_r;
        end
    end

    // Control FSM: IDLE -> SEARCH (d = 0..lim) -> DONE -> IDLE on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lim      <= '0;
            d        <= '0;
            run_min  <= '0;
            run_disp <= '0;
            best_q   <= '0;
            min_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lim      <= lim_in;
                        d        <= '0;
                        run_min  <= '1;
                        run_disp <= '0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    run_min  <= nxt_min;
                    run_disp <= nxt_disp;
                    if (d == lim) begin
                        best_q <= nxt_disp;
                        min_q  <= nxt_min;
                        state  <= DONE;
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAD_DISP_THRESH_EN
    logic ok_q;

    // Confidence flag latched alongside the final minimum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ok_q <= 1'b0;
        else if (state == SEARCH && d == lim)
            ok_q <= ({{(32-SAD_SIZE){1'b0}}, nxt_min} <= 32'(SAD_THRESH));
    end

    assign disp_ok = ok_q;
`else
    assign disp_ok = out_valid;
`endif

endmodule

// File: tb/tb_sad_disp_search.sv
// Scoreboard bench for sad_disp_search (WIN=3, DATA_SIZE=8, MAX_DISP=8).
// Stimulus pushes the reference answer into a queue at accept; a negedge
// monitor compares every presented result against the queue head.
module tb_sad_disp_search;
    localparam int WIN  = 3;
    localparam int DS   = 8;
    localparam int MD   = 8;
    localparam int SW   = WIN + MD - 1;
    localparam int SADW = 12;
    localparam int DW   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DS*WIN*WIN-1:0] win_l = '0;
    logic [DS*WIN*SW-1:0]  strip_r = '0;
    logic [DW-1:0]        disp_lim = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DW-1:0]        best_disp;
    logic [SADW-1:0]      min_sad;
    logic                 disp_ok;

    sad_disp_search #(
        .WIN        (WIN),
        .DATA_SIZE  (DS),
        .MAX_DISP   (MD),
        .SAD_THRESH (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_l     (win_l),
        .strip_r   (strip_r),
        .disp_lim  (disp_lim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .best_disp (best_disp),
        .min_sad   (min_sad),
        .disp_ok   (disp_ok)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int s;
        int ok;
        int lim;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   seen = 1'b0;
    int   L[WIN][WIN];
    int   S[WIN][SW];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference: evaluate every disparity in range, keep first strict minimum
    function automatic void model(input int lim, output int bd, output int bs);
        int s;
        bs = 32'h7fffffff;
        bd = 0;
        for (int dd = 0; dd <= lim; dd++) begin
            s = 0;
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    s += (L[r][c] > S[r][c+MD-1-dd]) ? L[r][c] - S[r][c+MD-1-dd]
                                                     : S[r][c+MD-1-dd] - L[r][c];
            if (s < bs) begin
                bs = s;
                bd = dd;
            end
        end
    endfunction

    function automatic int exp_ok(input int s);
`ifdef SAD_DISP_THRESH_EN
        return (s <= 1000) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic drive();
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++)
                win_l[(r*WIN+c)*DS +: DS] = DS'(L[r][c]);
            for (int k = 0; k < SW; k++)
                strip_r[(r*SW+k)*DS +: DS] = DS'(S[r][k]);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < WIN*WIN; i++) win_l[i*DS +: DS] = DS'($urandom);
        for (int i = 0; i < WIN*SW; i++) strip_r[i*DS +: DS] = DS'($urandom);
        disp_lim = DW'($urandom);
    endtask

    task automatic fill_strip(input int v);
        for (int r = 0; r < WIN; r++)
            for (int k = 0; k < SW; k++) S[r][k] = v;
    endtask

    task automatic ramp_left();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) L[r][c] = r*WIN + c + 1;
    endtask

    task automatic plant(input int dm);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) S[r][c+MD-1-dm] = L[r][c];
    endtask

    // Offer a job, push the expected answer at the accept edge
    task automatic start_job(input int lim, input int ed, input int es);
        int bd, bs, n;
        exp_t e;
        drive();
        disp_lim = DW'(lim);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        model(lim, bd, bs);
        if (ed >= 0) begin
            bd = ed;
            bs = es;
        end
        e.d = bd;
        e.s = bs;
        e.ok = exp_ok(bs);
        e.lim = lim;
        @(posedge clk);
        #1;
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        scramble();
        // out_ready during the search must be ignored
        if (lim >= 1) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    // Wait for the result, stall the consumer, then complete the handshake
    task automatic finish_job(input int stall);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            exp_q.delete();
            seen = 1'b0;
            return;
        end
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", int'(in_ready), 1);
        chk("out_valid_after_hs", int'(out_valid), 0);
    endtask

    task automatic run_job(input int lim, input int stall, input int ed, input int es);
        start_job(lim, ed, es);
        finish_job(stall);
    endtask

    // Monitor: every cycle a result is shown, it must match the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                mon_e = exp_q[0];
                chk("best_disp", int'(best_disp), mon_e.d);
                chk("min_sad", int'(min_sad), mon_e.s);
                chk("disp_ok", int'(disp_ok), mon_e.ok);
                chk("in_ready_busy", int'(in_ready), 0);
                if (!seen) begin
                    // d=0..lim take lim+1 edges after the accept edge
                    chk("latency", cyc - mon_e.acc, mon_e.lim + 1);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dm, lim;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_best_disp", int'(best_disp), 0);
        chk("rst_min_sad", int'(min_sad), 0);
        chk("rst_disp_ok", int'(disp_ok), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: exact match at d=3
        ramp_left();
        fill_strip(200);
        plant(3);
        run_job(7, 0, 3, 0);

        // 2: flat image, all SADs tie at zero
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) L[r][c] = 50;
        fill_strip(50);
        run_job(7, 1, 0, 0);

        // 3: worst-case SAD
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) L[r][c] = 255;
        fill_strip(0);
        run_job(7, 0, 0, 2295);

        // 4: match at d=5 lies outside the limited range 0..2
        ramp_left();
        fill_strip(200);
        plant(5);
        run_job(2, 0, 0, 1755);

        // disp_lim = 0: single evaluation
        run_job(0, 0, -1, -1);

        // 5: long consumer stall, then back-to-back job
        ramp_left();
        fill_strip(200);
        plant(3);
        run_job(7, 5, 3, 0);
        plant(6);
        run_job(7, 0, 3, 0);

        // 6: reset in the middle of a search
        ramp_left();
        fill_strip(200);
        plant(3);
        start_job(7, -1, -1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        seen = 1'b0;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_best_disp", int'(best_disp), 0);
        chk("arst_min_sad", int'(min_sad), 0);
        chk("arst_disp_ok", int'(disp_ok), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("no_stale_result", int'(out_valid), 0);
        end
        run_job(7, 0, 3, 0);

        // Random jobs
        for (int j = 0; j < 30; j++) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) L[r][c] = $urandom_range(255);
                for (int k = 0; k < SW; k++) S[r][k] = $urandom_range(255);
            end
            if ($urandom_range(1) == 1) begin
                dm = $urandom_range(MD-1);
                plant(dm);
            end
            lim = $urandom_range(MD-1);
            run_job(lim, $urandom_range(3), -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sad_disp_search.md
Name: sad_disp_search

Overview:
- Sequential successor to the combinational SAD/disparity compute path.
- Accepts one left WINxWIN window plus a right search strip, then evaluates one disparity per cycle through a single SAD datapath.
- Tracks the running minimum SAD and returns the best disparity over a valid/ready output handshake.
- Trades the per-column, per-disparity parallel array for one SAD unit, with a disparity range selectable at run time.

Parameters:
- WIN, 15, window edge length (odd, >=3).
- DATA_SIZE, 8, pixel bit width.
- MAX_DISP, 64, number of disparities supported (>=2).
- STRIP_W, WIN+MAX_DISP-1, right strip width in pixels (derived, do not override).
- SAD_SIZE, $clog2(WIN*WIN*((1<<DATA_SIZE)-1)+1), exact SAD width.
- DISP_W, $clog2(MAX_DISP), disparity index width.
- SAD_THRESH, 1000, confidence threshold (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  job offered.
- in_ready  out  1  block can accept a job.
- win_l  in  DATA_SIZE*WIN*WIN  left window; pixel (r,c) at index r*WIN+c, LSB-first.
- strip_r  in  DATA_SIZE*WIN*STRIP_W  right strip; pixel (r,k) at index r*STRIP_W+k, LSB-first.
- disp_lim  in  DISP_W  highest disparity to search, inclusive.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- best_disp  out  DISP_W  disparity with minimum SAD.
- min_sad  out  SAD_SIZE  SAD at best_disp.
- disp_ok  out  1  confidence flag (see Optional Feature).

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: IDLE, in_ready=1, out_valid=0, best_disp=0, min_sad=0, disp_ok=0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: register win_l, strip_r, and lim=min(disp_lim, MAX_DISP-1).
  - Clear d=0, run_min=all-ones, run_disp=0; go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle compute SAD(d) = sum over r,c of |L(r,c) - R(r, c+MAX_DISP-1-d)|, full SAD_SIZE width, no saturation.
  - If SAD(d) < run_min (strict), update run_min and run_disp. Ties keep the lower disparity.
  - If d==lim, go to DONE; else d=d+1.
  - d=0..lim occupy cycles T+1..T+lim+1.
- DONE:
  - out_valid=1 from T+lim+2.
  - best_disp=run_disp and min_sad=run_min, held stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid=0, go to IDLE. in_ready rises the next cycle, so there is no same-cycle accept.
- Latency: accept to out_valid is lim+2 cycles. Max throughput is one job per lim+3 cycles.
- disp_lim=0: exactly one SAD evaluated; out_valid at T+2.
- disp_lim>=MAX_DISP: clamped to MAX_DISP-1 (only reachable when MAX_DISP is not a power of 2).
- Inputs are sampled only at accept. Changes to win_l, strip_r or disp_lim after accept have no effect.
- Reset asserted in any state: immediate return to reset values. A partial search is discarded and no out_valid is produced for it.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the source must hold it.

Optional Feature:
- Macro: SAD_DISP_THRESH_EN.
- Defined: disp_ok=(min_sad <= SAD_THRESH), registered with the result; 0 in reset.
- Not defined: disp_ok=1 whenever out_valid=1, 0 otherwise. No threshold comparator is synthesised.

Test Plan:
All scenarios use WIN=3, DATA_SIZE=8, MAX_DISP=8, STRIP_W=10, SAD_THRESH=1000.
1. Left window = ramp 1..9; strip columns 4..6 (match for d=3) = same ramp; all other strip pixels 200; disp_lim=7 -> out_valid at T+9, best_disp=3, min_sad=0, disp_ok=1.
2. All left and strip pixels = 50, disp_lim=7 -> all SADs tie at 0 -> best_disp=0, min_sad=0.
3. Left all 255, strip all 0, disp_lim=7 -> best_disp=0, min_sad=2295; disp_ok=0 with SAD_DISP_THRESH_EN defined, 1 without.
4. Scenario 1 data with the match moved to d=5 and disp_lim=2 -> only d=0..2 searched; out_valid at T+4; best_disp is the smallest-SAD index in 0..2, never 5.
5. Scenario 1 with out_ready held low for 5 cycles -> best_disp=3 and min_sad=0 stable, in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle and a second job is accepted.
6. Assert rst_n low during SEARCH at d=4 -> out_valid=0, in_ready=1, best_disp=0, min_sad=0 asynchronously; no stale result after release; a fresh job completes normally.
